// File: rtl/codificador_programa.sv
// Instruction encoder and program loader: packs one-hot op/mode plus operand
// into 16-bit words and writes them to consecutive program-memory addresses,
// optionally terminating the program with an HLT word.
module codificador_programa #(
    parameter int ADDR_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              entrada_valida,
    output logic              entrada_pronta,
    input  logic [15:0]       operacao,
    input  logic [3:0]        modo,
    input  logic [8:0]        operando,
    input  logic              finalizar,
    output logic              mem_escrita,
    output logic [ADDR_W-1:0] mem_endereco,
    output logic [15:0]       mem_dado,
    output logic [ADDR_W:0]   contagem,
    output logic              cheio,
    output logic              concluido,
    output logic              erro,
    output logic [1:0]        cod_erro
);

    localparam logic [2:0] OCIOSO      = 3'd0;
    localparam logic [2:0] ESCREVE     = 3'd1;
    localparam logic [2:0] CHEIO       = 3'd2;
    localparam logic [2:0] FIM_ESCREVE = 3'd3;
    localparam logic [2:0] FIM         = 3'd4;

    localparam logic [15:0] PALAVRA_HLT = {5'd15, 2'b11, 9'd0};

    logic [2:0]        estado_q, estado_d;
    logic [ADDR_W:0]   cont_q, cont_d;
    logic [ADDR_W-1:0] end_q, end_d;
    logic [15:0]       dado_q, dado_d;
    logic              erro_q, erro_d;
    logic [1:0]        cod_q, cod_d;

    logic [3:0]        op_idx;
    logic [1:0]        modo_idx;
    logic              op_ok;
    logic              modo_ok;
    logic [15:0]       palavra;
    logic [ADDR_W-1:0] ponteiro;

    // Contagem doubles as write pointer; its MSB is set only when memory is full.
    assign ponteiro = cont_q[ADDR_W-1:0];

    // Field validation and packing of the one-hot inputs into the word format
    always_comb begin
        op_idx   = '0;
        modo_idx = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (operacao[i]) op_idx = 4'(15 - i);
        end
        for (int unsigned i = 0; i < 4; i++) begin
            if (modo[i]) modo_idx = 2'(3 - i);
        end
        op_ok   = (operacao != '0) && ((operacao & (operacao - 16'd1)) == '0);
        modo_ok = (modo != '0) && ((modo & (modo - 4'd1)) == '0);
        palavra = {1'b0, op_idx, modo_idx, operando};
    end

    // Next-state logic for the loader FSM, pointer and sticky error flags
    always_comb begin
        estado_d = estado_q;
        cont_d   = cont_q;
        end_d    = end_q;
        dado_d   = dado_q;
        erro_d   = erro_q;
        cod_d    = cod_q;
        case (estado_q)
            OCIOSO: begin
                if (finalizar) begin
                    dado_d   = PALAVRA_HLT;
                    end_d    = ponteiro;
                    estado_d = FIM_ESCREVE;
                end else if (entrada_valida) begin
                    if (op_ok && modo_ok) begin
                        dado_d   = palavra;
                        end_d    = ponteiro;
                        estado_d = ESCREVE;
                    end else begin
                        erro_d = 1'b1;
                        cod_d  = cod_q | {~modo_ok, ~op_ok};
                    end
                end
            end
            ESCREVE: begin
                cont_d   = cont_q + 1'b1;
                estado_d = (ponteiro == '1) ? CHEIO : OCIOSO;
            end
            CHEIO: begin
                if (finalizar) estado_d = FIM;
            end
            FIM_ESCREVE: begin
                cont_d   = cont_q + 1'b1;
                estado_d = FIM;
            end
            FIM: begin
                estado_d = FIM;
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase
    end

    // State registers with synchronous reset; a pending word is simply dropped
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= OCIOSO;
            cont_q   <= '0;
            end_q    <= '0;
            dado_q   <= '0;
            erro_q   <= 1'b0;
            cod_q    <= '0;
        end else begin
            estado_q <= estado_d;
            cont_q   <= cont_d;
            end_q    <= end_d;
            dado_q   <= dado_d;
            erro_q   <= erro_d;
            cod_q    <= cod_d;
        end
    end

    assign entrada_pronta = (estado_q == OCIOSO);
    assign mem_escrita    = (estado_q == ESCREVE) || (estado_q == FIM_ESCREVE);
    assign mem_endereco   = end_q;
    assign mem_dado       = dado_q;
    assign contagem       = cont_q;
    assign cheio          = cont_q[ADDR_W];
    assign concluido      = (estado_q == FIM);
    assign erro           = erro_q;
    assign cod_erro       = cod_q;

endmodule

// File: tb/tb_codificador_programa.sv
// Scoreboard bench for codificador_programa: two instances (default width and
// a 4-word memory) share stimulus; a per-instance reference model predicts
// writes and status, a negedge monitor compares.
module tb_codificador_programa;

    logic        clock = 1'b0;
    logic        reset;
    logic        entrada_valida;
    logic [15:0] operacao;
    logic [3:0]  modo;
    logic [8:0]  operando;
    logic        finalizar;

    logic        p8, e8, ch8, co8, er8;
    logic [7:0]  a8;
    logic [15:0] d8;
    logic [8:0]  c8;
    logic [1:0]  ce8;

    logic        p2, e2, ch2, co2, er2;
    logic [1:0]  a2;
    logic [15:0] d2;
    logic [2:0]  c2;
    logic [1:0]  ce2;

    int checks = 0;
    int errors = 0;
    bit armed  = 1'b0;

    always #5 clock = ~clock;

    codificador_programa dut8 (
        .clock(clock), .reset(reset), .entrada_valida(entrada_valida),
        .entrada_pronta(p8), .operacao(operacao), .modo(modo),
        .operando(operando), .finalizar(finalizar), .mem_escrita(e8),
        .mem_endereco(a8), .mem_dado(d8), .contagem(c8), .cheio(ch8),
        .concluido(co8), .erro(er8), .cod_erro(ce8)
    );

    codificador_programa #(.ADDR_W(2)) dut2 (
        .clock(clock), .reset(reset), .entrada_valida(entrada_valida),
        .entrada_pronta(p2), .operacao(operacao), .modo(modo),
        .operando(operando), .finalizar(finalizar), .mem_escrita(e2),
        .mem_endereco(a2), .mem_dado(d2), .contagem(c2), .cheio(ch2),
        .concluido(co2), .erro(er2), .cod_erro(ce2)
    );

    typedef struct {
        int unsigned cap;
        int unsigned count;
        bit          pend;
        bit          hlt;
        bit          done;
        bit          err;
        bit [1:0]    cod;
        int unsigned last_addr;
        bit [15:0]   last_data;
    } model_t;

    typedef struct {
        int unsigned addr;
        bit [15:0]   data;
    } wr_t;

    model_t m[2];
    wr_t    sb[2][$];

    task automatic chk(input int k, input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL inst%0d %s: got 0x%0h expected 0x%0h at %0t", k, name, act, exp, $time);
        end
    endtask

    task automatic model_reset(input int k);
        m[k].count = 0; m[k].pend = 0; m[k].hlt = 0; m[k].done = 0;
        m[k].err = 0; m[k].cod = 0; m[k].last_addr = 0; m[k].last_data = 0;
        sb[k].delete();
    endtask

    task automatic push_write(input int k, input bit [15:0] w);
        wr_t x;
        x.addr = m[k].count;
        x.data = w;
        sb[k].push_back(x);
        m[k].last_addr = x.addr;
        m[k].last_data = w;
        m[k].pend = 1;
    endtask

    // Reference behaviour: one step per clock edge using the sampled inputs
    task automatic model_step(input int k);
        bit op_ok, md_ok;
        int unsigned word;
        if (reset) begin
            model_reset(k);
            return;
        end
        op_ok = ($countones(operacao) == 1);
        md_ok = ($countones(modo) == 1);
        if (m[k].pend) begin
            m[k].count++;
            m[k].pend = 0;
            if (m[k].hlt) m[k].done = 1;
        end else if (m[k].done) begin
        end else if (m[k].count == m[k].cap) begin
            if (finalizar) m[k].done = 1;
        end else if (finalizar) begin
            m[k].hlt = 1;
            push_write(k, 16'h7E00);
        end else if (entrada_valida) begin
            if (op_ok && md_ok) begin
                word = (15 - $clog2(operacao)) * 2048 + (3 - $clog2(modo)) * 512 + operando;
                m[k].hlt = 0;
                push_write(k, word[15:0]);
            end else begin
                m[k].err = 1;
                m[k].cod = m[k].cod | {!md_ok, !op_ok};
            end
        end
    endtask

    always @(posedge clock) begin
        model_step(0);
        model_step(1);
        armed <= armed | reset;
    end

    task automatic monitor(input int k, input bit esc, input int unsigned addr, input int unsigned data,
                           input int unsigned cont, input bit pr, input bit ch, input bit co,
                           input bit er, input int unsigned ce);
        wr_t x;
        chk(k, "mem_escrita", esc, m[k].pend);
        if (esc && m[k].pend) begin
            if (sb[k].size() == 0) begin
                chk(k, "scoreboard_empty", 1, 0);
            end else begin
                x = sb[k].pop_front();
                chk(k, "write_addr", addr, x.addr);
                chk(k, "write_data", data, x.data);
            end
        end else if (!esc) begin
            chk(k, "held_addr", addr, m[k].last_addr);
            chk(k, "held_data", data, m[k].last_data);
        end
        chk(k, "contagem", cont, m[k].count);
        chk(k, "entrada_pronta", pr, !m[k].pend && !m[k].done && (m[k].count < m[k].cap));
        chk(k, "cheio", ch, m[k].count == m[k].cap);
        chk(k, "concluido", co, m[k].done);
        chk(k, "erro", er, m[k].err);
        chk(k, "cod_erro", ce, m[k].cod);
    endtask

    always @(negedge clock) begin
        if (armed) begin
            monitor(0, e8, a8, d8, c8, p8, ch8, co8, er8, ce8);
            monitor(1, e2, a2, d2, c2, p2, ch2, co2, er2, ce2);
        end
    end

    task automatic cyc(input bit v, input logic [15:0] op, input logic [3:0] md,
                       input logic [8:0] opnd, input bit fin, input bit rst);
        entrada_valida = v; operacao = op; modo = md; operando = opnd;
        finalizar = fin; reset = rst;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 16'h0, 4'h0, 9'h0, 0, 0);
    endtask

    task automatic do_reset();
        cyc(0, 16'h0, 4'h0, 9'h0, 0, 1);
    endtask

    initial begin
        logic [15:0] op;
        logic [3:0]  md;
        int unsigned r;
        m[0].cap = 256;
        m[1].cap = 4;
        model_reset(0);
        model_reset(1);

        cyc(0, 16'h0, 4'h0, 9'h0, 0, 1);
        do_reset();
        idle(1);

        // LDA IM 0x05A
        cyc(1, 16'h2000, 4'h2, 9'h05A, 0, 0);
        chk(0, "lda_word", d8, 16'h145A);
        chk(0, "lda_strobe", e8, 1);
        idle(2);
        chk(0, "lda_count", c8, 1);

        // ADD DIR 0x1FF then finalizar, then ignored valids
        do_reset();
        cyc(1, 16'h1000, 4'h8, 9'h1FF, 0, 0);
        idle(1);
        cyc(0, 16'h0, 4'h0, 9'h0, 1, 0);
        chk(0, "hlt_word", d8, 16'h7E00);
        idle(1);
        for (int i = 0; i < 3; i++) cyc(1, 16'h0800, 4'h1, 9'h003, 0, 0);
        chk(0, "fim_concluido", co8, 1);
        chk(0, "fim_count", c8, 2);

        // two invalid instructions
        do_reset();
        cyc(1, 16'h3000, 4'h8, 9'h010, 0, 0);
        cyc(1, 16'h0001, 4'h0, 9'h020, 0, 0);
        idle(1);
        chk(0, "invalid_cod", ce8, 2'b11);
        chk(0, "invalid_count", c8, 0);

        // fill the 4-word instance, then extra valid and finalizar
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cyc(1, 16'h0400 >> i, 4'h4, 9'(i * 7), 0, 0);
            idle(1);
        end
        chk(1, "full_count", c2, 4);
        chk(1, "full_cheio", ch2, 1);
        cyc(1, 16'h0002, 4'h2, 9'h0AA, 0, 0);
        idle(1);
        cyc(0, 16'h0, 4'h0, 9'h0, 1, 0);
        idle(1);
        chk(1, "full_concluido", co2, 1);

        // finalizar wins over a simultaneous valid
        do_reset();
        cyc(1, 16'h0200, 4'h8, 9'h111, 0, 0);
        idle(1);
        cyc(1, 16'h4000, 4'h8, 9'h055, 1, 0);
        chk(0, "fin_wins_word", d8, 16'h7E00);
        chk(0, "fin_wins_addr", a8, 1);
        idle(2);

        // reset during the write cycle discards the word
        do_reset();
        cyc(1, 16'h0100, 4'h2, 9'h033, 0, 0);
        cyc(0, 16'h0, 4'h0, 9'h0, 0, 1);
        chk(0, "rst_escrita", e8, 0);
        chk(0, "rst_pronta", p8, 1);
        cyc(1, 16'h0080, 4'h1, 9'h044, 0, 0);
        chk(0, "rst_next_addr", a8, 0);
        idle(2);

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            r = $urandom_range(0, 9);
            if (r < 7)       op = 16'h1 << $urandom_range(0, 15);
            else if (r == 7) op = 16'h0;
            else             op = 16'($urandom);
            r = $urandom_range(0, 9);
            if (r < 8)       md = 4'h1 << $urandom_range(0, 3);
            else if (r == 8) md = 4'h0;
            else             md = 4'($urandom);
            cyc($urandom_range(0, 1) == 1, op, md, 9'($urandom),
                $urandom_range(0, 59) == 0, $urandom_range(0, 119) == 0);
        end
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
